// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared opcode constants, ID/EX control word and FSM state type
//             for the ctrl_pipe control/hazard block.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [6:0] c_opRtype  = 7'b0110011;
    localparam logic [6:0] c_opItype  = 7'b0010011;
    localparam logic [6:0] c_opLoad   = 7'b0000011;
    localparam logic [6:0] c_opStore  = 7'b0100011;
    localparam logic [6:0] c_opBranch = 7'b1100011;

    typedef struct packed {
        logic       regWrite;
        logic       memToReg;
        logic       memRead;
        logic       memWrite;
        logic [1:0] aluOp;
        logic       aluSrc;
        logic       branch;
    } ctrl_word_t;

    localparam ctrl_word_t c_ctrlBubble = '0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_decode
//  Purpose  : Combinational opcode decoder; unknown opcodes yield a bubble
//             control word and raise the illegal flag.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]  op_i,
    output ctrl_word_t  ctrl_o,
    output logic        illegal_o
);

    always_comb begin
        ctrl_o    = c_ctrlBubble;
        illegal_o = 1'b0;
        case (op_i)
            c_opRtype: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.aluOp    = 2'b10;
            end
            c_opItype: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.aluOp    = 2'b11;
                ctrl_o.aluSrc   = 1'b1;
            end
            c_opLoad: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.memToReg = 1'b1;
                ctrl_o.memRead  = 1'b1;
                ctrl_o.aluSrc   = 1'b1;
            end
            c_opStore: begin
                ctrl_o.memWrite = 1'b1;
                ctrl_o.aluSrc   = 1'b1;
            end
            c_opBranch: begin
                ctrl_o.aluOp    = 2'b01;
                ctrl_o.branch   = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe
//  Purpose  : ID-stage control: decode into the ID/EX register, load-use
//             stall FSM (LOAD_LAT bubbles, legal 1..3), branch flush and
//             optional perf counters (enabled by CTRL_PIPE_PERF_CNT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [6:0]        op_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              branch_taken_i,
    output logic              ex_regwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic [1:0]        ex_aluop_o,
    output logic              ex_alusrc_o,
    output logic              ex_branch_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // Two bits cover the largest remaining-stall count (LOAD_LAT-1 = 2).
    localparam logic [1:0] c_latInit = 2'(LOAD_LAT - 1);

    ctrl_word_t        w_decCtrl;
    logic              w_decIllegal;
    logic              w_hazard;
    logic              w_issue;
    state_t            r_state;
    state_t            w_nextState;
    logic [1:0]        r_latCnt;
    logic [1:0]        w_nextLatCnt;
    ctrl_word_t        r_exCtrl;
    logic [REG_AW-1:0] r_exRd;
    logic              r_illegal;

    ctrl_decode u_decode (
        .op_i      (op_i),
        .ctrl_o    (w_decCtrl),
        .illegal_o (w_decIllegal)
    );

    // A bubble in EX has rd 0 and memRead 0, so it can never match.
    assign w_hazard = valid_i & r_exCtrl.memRead & (r_exRd != '0) &
                      ((r_exRd == rs1_i) | (r_exRd == rs2_i));

    assign flush_o  = branch_taken_i & valid_i;
    assign stall_o  = ~flush_o & ((r_state == ST_STALL) | w_hazard);
    assign w_issue  = valid_i & ~stall_o & ~flush_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_RUN;
            r_latCnt <= 2'd0;
        end else begin
            r_state  <= w_nextState;
            r_latCnt <= w_nextLatCnt;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextLatCnt = r_latCnt;
        case (r_state)
            ST_RUN: begin
                if (w_hazard && !flush_o && (LOAD_LAT > 1)) begin
                    w_nextState  = ST_STALL;
                    w_nextLatCnt = c_latInit;
                end
            end
            ST_STALL: begin
                if (flush_o || (r_latCnt == 2'd1)) begin
                    w_nextState  = ST_RUN;
                    w_nextLatCnt = 2'd0;
                end else begin
                    w_nextLatCnt = r_latCnt - 2'd1;
                end
            end
            default: begin
                w_nextState  = ST_RUN;
                w_nextLatCnt = 2'd0;
            end
        endcase
    end

    // Illegal is reported only when the instruction would really have issued,
    // so a held (stalled) instruction does not pulse repeatedly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_exCtrl  <= c_ctrlBubble;
            r_exRd    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_exCtrl  <= w_issue ? w_decCtrl : c_ctrlBubble;
            r_exRd    <= (w_issue && !w_decIllegal) ? rd_i : '0;
            r_illegal <= w_issue & w_decIllegal;
        end
    end

    assign ex_regwrite_o = r_exCtrl.regWrite;
    assign ex_memtoreg_o = r_exCtrl.memToReg;
    assign ex_memread_o  = r_exCtrl.memRead;
    assign ex_memwrite_o = r_exCtrl.memWrite;
    assign ex_aluop_o    = r_exCtrl.aluOp;
    assign ex_alusrc_o   = r_exCtrl.aluSrc;
    assign ex_branch_o   = r_exCtrl.branch;
    assign ex_rd_o       = r_exRd;
    assign illegal_o     = r_illegal;

`ifdef CTRL_PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_cntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    // Saturating event counters: they stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (stall_o && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + c_cntOne;
            if (flush_o && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + c_cntOne;
        end
    end

    assign stall_cnt_o = r_stallCnt;
    assign flush_cnt_o = r_flushCnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule : ctrl_pipe
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_pipe
//  Purpose  : Self-checking bench for ctrl_pipe; runs a LOAD_LAT=1 and a
//             LOAD_LAT=3 (CNT_W=4) instance side by side on shared stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [7:0] W_ADD  = 8'b1000_1000;

`ifdef CTRL_PIPE_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       br = 1'b0;
    logic [6:0] op = '0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

    logic [1:0] rw, m2r, mr, mw, asrc, bra, dStall, dFlush, dIll;
    logic [1:0] aop0, aop1;
    logic [4:0] dRd [2];
    logic [7:0] dCtrl [2];
    logic [15:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .branch_taken_i(br),
        .ex_regwrite_o(rw[0]), .ex_memtoreg_o(m2r[0]), .ex_memread_o(mr[0]),
        .ex_memwrite_o(mw[0]), .ex_aluop_o(aop0), .ex_alusrc_o(asrc[0]),
        .ex_branch_o(bra[0]), .ex_rd_o(dRd[0]), .stall_o(dStall[0]),
        .flush_o(dFlush[0]), .illegal_o(dIll[0]),
        .stall_cnt_o(sc0), .flush_cnt_o(fc0)
    );

    ctrl_pipe #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) dut3 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .branch_taken_i(br),
        .ex_regwrite_o(rw[1]), .ex_memtoreg_o(m2r[1]), .ex_memread_o(mr[1]),
        .ex_memwrite_o(mw[1]), .ex_aluop_o(aop1), .ex_alusrc_o(asrc[1]),
        .ex_branch_o(bra[1]), .ex_rd_o(dRd[1]), .stall_o(dStall[1]),
        .flush_o(dFlush[1]), .illegal_o(dIll[1]),
        .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    assign dCtrl[0] = {rw[0], m2r[0], mr[0], mw[0], aop0, asrc[0], bra[0]};
    assign dCtrl[1] = {rw[1], m2r[1], mr[1], mw[1], aop1, asrc[1], bra[1]};

    // Reference model: instruction-level view with a stall countdown.
    int       LAT  [2] = '{1, 3};
    int       MAXC [2] = '{65535, 15};
    int       mLeft[2], mPrevRd[2], mRd[2], mSCnt[2], mFCnt[2];
    bit       mPrevLoad[2], mIll[2], mStall[2];
    bit       mFlush;
    logic [7:0] mCtrl[2];

    function automatic logic [8:0] refDecode(input logic [6:0] o);
        case (o)
            7'b0110011: return {1'b1, 8'b1000_1000};
            7'b0010011: return {1'b1, 8'b1000_1110};
            7'b0000011: return {1'b1, 8'b1110_0010};
            7'b0100011: return {1'b1, 8'b0001_0010};
            7'b1100011: return {1'b1, 8'b0000_0101};
            default:    return 9'd0;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [6:0] o, input int a,
                         input int b, input int d, input bit t);
        valid = v; op = o; rs1 = 5'(a); rs2 = 5'(b); rd = 5'(d); br = t;
    endtask

    task automatic settle();
        #1;
        mFlush = valid && br;
        for (int i = 0; i < 2; i++) begin
            if (mFlush)             mStall[i] = 1'b0;
            else if (mLeft[i] > 0)  mStall[i] = 1'b1;
            else mStall[i] = valid && mPrevLoad[i] && (mPrevRd[i] != 0) &&
                             ((mPrevRd[i] == int'(rs1)) || (mPrevRd[i] == int'(rs2)));
        end
    endtask

    task automatic tick();
        logic [8:0] dec;
        bit         issue;
        dec = refDecode(op);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mLeft[i] = 0; mPrevLoad[i] = 0; mPrevRd[i] = 0; mCtrl[i] = '0;
                mRd[i] = 0; mIll[i] = 0; mSCnt[i] = 0; mFCnt[i] = 0;
            end else begin
                if (mFlush)            mLeft[i] = 0;
                else if (mLeft[i] > 0) mLeft[i] = mLeft[i] - 1;
                else if (mStall[i])    mLeft[i] = LAT[i] - 1;
                issue        = valid && !mStall[i] && !mFlush;
                mCtrl[i]     = (issue && dec[8]) ? dec[7:0] : 8'd0;
                mRd[i]       = (issue && dec[8]) ? int'(rd) : 0;
                mPrevLoad[i] = mCtrl[i][5];
                mPrevRd[i]   = mRd[i];
                mIll[i]      = issue && !dec[8];
                if (mStall[i] && mSCnt[i] < MAXC[i]) mSCnt[i]++;
                if (mFlush && mFCnt[i] < MAXC[i])    mFCnt[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, '0, 0, 0, 0, 0);
        settle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (dCtrl[i] !== 8'd0 || dRd[i] !== 5'd0 || dIll[i] !== 1'b0) begin
                nFail++;
                $display("FAIL reset_ex dut%0d: ctrl=%b rd=%0d ill=%b, required 0", i, dCtrl[i], dRd[i], dIll[i]);
            end
            nChecks++;
            if (dStall[i] !== 1'b0 || dFlush[i] !== 1'b0) begin
                nFail++;
                $display("FAIL reset_comb dut%0d: stall=%b flush=%b, required 0", i, dStall[i], dFlush[i]);
            end
        end
        nChecks++;
        if (sc0 !== 16'd0 || fc0 !== 16'd0 || sc1 !== 4'd0 || fc1 !== 4'd0) begin
            nFail++;
            $display("FAIL reset_cnt: %0d %0d %0d %0d, required 0", sc0, fc0, sc1, fc1);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, OP_LW, 0, 0, 5, 0); settle(); tick();
        drive(1, OP_ADD, 5, 0, 7, 0);
        for (int k = 0; k < 4; k++) begin
            settle();
            nChecks++;
            if (dStall[0] !== (k == 0) || dStall[1] !== (k < 3)) begin
                nFail++;
                $display("FAIL load_use_stall k=%0d: got %b/%b, required %b/%b", k, dStall[0], dStall[1], k == 0, k < 3);
            end
            tick();
            nChecks++;
            if (dCtrl[0] !== ((k >= 1) ? W_ADD : 8'd0) || dCtrl[1] !== ((k == 3) ? W_ADD : 8'd0)) begin
                nFail++;
                $display("FAIL load_use_ctrl k=%0d: got %b/%b", k, dCtrl[0], dCtrl[1]);
            end
            nChecks++;
            if (dRd[1] !== ((k == 3) ? 5'd7 : 5'd0)) begin
                nFail++;
                $display("FAIL load_use_rd k=%0d: got %0d", k, dRd[1]);
            end
        end
    endtask

    task automatic test_x0();
        do_reset();
        drive(1, OP_LW, 0, 0, 0, 0); settle(); tick();
        drive(1, OP_ADD, 0, 0, 7, 0); settle();
        nChecks++;
        if (dStall !== 2'b00) begin
            nFail++;
            $display("FAIL x0_stall: got %b, required 00", dStall);
        end
        tick();
        nChecks++;
        if (dCtrl[0] !== W_ADD || dCtrl[1] !== W_ADD) begin
            nFail++;
            $display("FAIL x0_issue: got %b/%b, required %b", dCtrl[0], dCtrl[1], W_ADD);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, OP_LW, 0, 0, 5, 0); settle(); tick();
        drive(1, OP_ADD, 5, 0, 7, 1); settle();
        nChecks++;
        if (dFlush !== 2'b11 || dStall !== 2'b00) begin
            nFail++;
            $display("FAIL flush_prio: flush=%b stall=%b, required 11/00", dFlush, dStall);
        end
        tick();
        nChecks++;
        if (dCtrl[0] !== 8'd0 || dCtrl[1] !== 8'd0) begin
            nFail++;
            $display("FAIL flush_bubble: got %b/%b, required 0", dCtrl[0], dCtrl[1]);
        end
        drive(1, OP_LW, 0, 0, 5, 0); settle(); tick();
        drive(1, OP_ADD, 5, 0, 7, 0); settle();
        nChecks++;
        if (dStall[1] !== 1'b1) begin
            nFail++;
            $display("FAIL flush_pre_stall: got %b, required 1", dStall[1]);
        end
        tick();
        drive(1, OP_ADD, 5, 0, 7, 1); settle();
        nChecks++;
        if (dFlush[1] !== 1'b1 || dStall[1] !== 1'b0) begin
            nFail++;
            $display("FAIL flush_mid_stall: flush=%b stall=%b, required 1/0", dFlush[1], dStall[1]);
        end
        tick();
        drive(1, OP_ADD, 5, 0, 7, 0); settle();
        nChecks++;
        if (dStall[1] !== 1'b0) begin
            nFail++;
            $display("FAIL flush_abort: stall=%b, required 0", dStall[1]);
        end
        tick();
        nChecks++;
        if (dCtrl[1] !== W_ADD) begin
            nFail++;
            $display("FAIL flush_resume: got %b, required %b", dCtrl[1], W_ADD);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1, 7'b1111111, 1, 2, 3, 0); settle(); tick();
        nChecks++;
        if (dIll !== 2'b11 || dCtrl[0] !== 8'd0 || dRd[0] !== 5'd0) begin
            nFail++;
            $display("FAIL illegal_pulse: ill=%b ctrl=%b rd=%0d, required 11/0/0", dIll, dCtrl[0], dRd[0]);
        end
        drive(0, '0, 0, 0, 0, 0); settle(); tick();
        nChecks++;
        if (dIll !== 2'b00) begin
            nFail++;
            $display("FAIL illegal_once: ill=%b, required 00", dIll);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, OP_LW, 0, 0, 5, 0); settle(); tick();
        drive(1, OP_ADD, 5, 0, 7, 0); settle(); tick();
        rst = 1'b1; settle(); tick(); rst = 1'b0;
        nChecks++;
        if (dCtrl[1] !== 8'd0 || dRd[1] !== 5'd0 || dIll[1] !== 1'b0 || sc1 !== 4'd0) begin
            nFail++;
            $display("FAIL rst_mid_stall: ctrl=%b rd=%0d ill=%b cnt=%0d, required 0", dCtrl[1], dRd[1], dIll[1], sc1);
        end
        settle();
        nChecks++;
        if (dStall[1] !== 1'b0) begin
            nFail++;
            $display("FAIL rst_abort: stall=%b, required 0", dStall[1]);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, OP_LW, 5, 5, 5, 0);
        repeat (28) begin settle(); tick(); end
        nChecks++;
        if (sc1 !== (CNT_EN ? 4'd15 : 4'd0) || sc0 !== (CNT_EN ? 16'd14 : 16'd0)) begin
            nFail++;
            $display("FAIL stall_cnt_sat: got %0d/%0d, required %0d/%0d", sc0, sc1, CNT_EN ? 14 : 0, CNT_EN ? 15 : 0);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0000000};
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 9) < 8, ops[$urandom_range(0, 5)],
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            settle();
            for (int i = 0; i < 2; i++) begin
                nChecks++;
                if (dStall[i] !== mStall[i] || dFlush[i] !== mFlush) begin
                    nFail++;
                    $display("FAIL rand_comb n=%0d dut%0d: stall=%b flush=%b, required %b/%b", n, i, dStall[i], dFlush[i], mStall[i], mFlush);
                end
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                nChecks++;
                if (dCtrl[i] !== mCtrl[i] || dRd[i] !== 5'(mRd[i]) || dIll[i] !== mIll[i]) begin
                    nFail++;
                    $display("FAIL rand_ex n=%0d dut%0d: ctrl=%b rd=%0d ill=%b, required %b/%0d/%b", n, i, dCtrl[i], dRd[i], dIll[i], mCtrl[i], mRd[i], mIll[i]);
                end
            end
            nChecks++;
            if (sc0 !== 16'(CNT_EN ? mSCnt[0] : 0) || fc0 !== 16'(CNT_EN ? mFCnt[0] : 0) ||
                sc1 !== 4'(CNT_EN ? mSCnt[1] : 0) || fc1 !== 4'(CNT_EN ? mFCnt[1] : 0)) begin
                nFail++;
                $display("FAIL rand_cnt n=%0d: got %0d %0d %0d %0d", n, sc0, fc0, sc1, fc1);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_flush();
        test_illegal();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule : tb_ctrl_pipe
`default_nettype wire

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  REG_AW  5   register-address width
  LOAD_LAT  1   load-use bubble cycles, legal 1..3
  CNT_W  16   perf-counter width
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
  clk_i  in  1  clock
  rst_i  in  1  reset
  valid_i  in  1  ID-stage instruction valid
  op_i  in  7  ID opcode
  rs1_i  in  REG_AW  ID source 1
  rs2_i  in  REG_AW  ID source 2
  rd_i  in  REG_AW  ID destination
  branch_taken_i  in  1  taken branch resolved in ID
  ex_regwrite_o  out  1  ID/EX RegWrite
  ex_memtoreg_o  out  1  ID/EX MemtoReg
  ex_memread_o  out  1  ID/EX MemRead
  ex_memwrite_o  out  1  ID/EX MemWrite
  ex_aluop_o  out  2  ID/EX ALUOp
  ex_alusrc_o  out  1  ID/EX ALUSrc
  ex_branch_o  out  1  ID/EX Branch
  ex_rd_o  out  REG_AW  ID/EX destination
  stall_o  out  1  hold PC and IF/ID (combinational)
  flush_o  out  1  squash IF/ID (combinational)
  illegal_o  out  1  registered one-cycle unknown-opcode pulse
  stall_cnt_o  out  CNT_W  stall-cycle count
  flush_cnt_o  out  CNT_W  flush count
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL decode {RegWrite,MemtoReg,MemRead,MemWrite,ALUOp,ALUSrc,Branch}: 0110011 -> 1,0,0,0,10,0,0; 0010011 -> 1,0,0,0,11,1,0; 0000011 -> 1,1,1,0,00,1,0; 0100011 -> 0,0,0,1,00,1,0; 1100011 -> 0,0,0,0,01,0,1.
REQ-005 SHALL treat any other opcode as a bubble and set illegal_o for the next cycle only.
REQ-006 SHALL register the decoded word and rd_i into the ID/EX outputs at each clk_i edge; latency one cycle.
REQ-007 SHALL define a bubble as all control outputs 0 and ex_rd_o 0.
REQ-008 SHALL load a bubble when valid_i=0, stall_o=1 or flush_o=1.
REQ-009 SHALL detect load-use hazard: valid_i & ex_memread_o & ex_rd_o!=0 & (ex_rd_o==rs1_i | ex_rd_o==rs2_i).
REQ-010 SHALL implement FSM RUN/STALL; in RUN, hazard asserts stall_o; if LOAD_LAT>1 go STALL with count LOAD_LAT-1, else stay RUN.
REQ-011 In STALL SHALL assert stall_o, decrement count each cycle, return to RUN at the edge where count is 1; total stall = LOAD_LAT cycles.
REQ-012 SHALL drive flush_o = branch_taken_i & valid_i; flush has priority: stall_o forced 0, any STALL aborted to RUN next edge.
REQ-013 SHALL never detect a hazard against a bubble (rd 0 excludes x0).

Reset
REQ-014 rst_i SHALL clear all ID/EX outputs, illegal_o, counters, force RUN with count 0; reset mid-stall SHALL abort it.

Configuration
REQ-015 With CTRL_PIPE_PERF_CNT_EN defined, stall_cnt_o/flush_cnt_o SHALL count cycles with stall_o/flush_o high, saturating at all-ones; without it both SHALL be constant 0, no counter flops.

Structure
REQ-016 Opcode constants, control-word struct and FSM state enum SHALL live in shared package ctrl_pkg.
REQ-017 Decoder SHALL be sub-module ctrl_decode (combinational, op_i -> control word, illegal flag).

Verification
REQ-018 lw x5 (0000011,rd=5) then add rs1=5, LOAD_LAT=1 -> stall_o 1 cycle, one bubble, add issued next cycle.
REQ-019 Same with LOAD_LAT=3 -> stall_o 3 consecutive cycles, 3 bubbles, then add control 1,0,0,0,10,0,0.
REQ-020 lw x0 then add rs1=0 -> no stall.
REQ-021 Hazard cycle with branch_taken_i=1 -> flush_o=1, stall_o=0; LOAD_LAT=3 stall in progress + branch -> RUN next edge.
REQ-022 op_i=1111111 -> bubble, illegal_o high exactly one cycle; rst_i mid-STALL -> all outputs 0 next edge.
REQ-023 With CTRL_PIPE_PERF_CNT_EN, CNT_W=4, 20 stall cycles -> stall_cnt_o saturates at 15.
